// File: rtl/lsu_ctrl.sv
// lsu_ctrl: byte-addressed load/store controller in front of a 64-bit
// word-addressed RAM. Misaligned accesses may span two RAM words; stores
// are merged by read-modify-write unless they cover a whole aligned word.
module lsu_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int RAM_SIZE   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [63:0]           req_addr_i,
   input  logic [2:0]            req_wid_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic [RAM_SIZE-1:0]   ram_addr_o,
   output logic                  ram_ewr_o,
   output logic [2:0]            ram_wid_o,
   output logic [DATA_WIDTH-1:0] ram_data_o,
   input  logic [DATA_WIDTH-1:0] ram_data_i
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD0  = 3'd1;
   localparam logic [2:0] S_RD1  = 3'd2;
   localparam logic [2:0] S_WR0  = 3'd3;
   localparam logic [2:0] S_WR1  = 3'd4;
   localparam logic [2:0] S_RESP = 3'd5;

   localparam logic [RAM_SIZE-1:0] WORD_LAST = {RAM_SIZE{1'b1}};
   localparam logic [RAM_SIZE-1:0] WORD_ONE  = {{(RAM_SIZE-1){1'b0}}, 1'b1};

   // Access size in bytes from the width code (low two bits select 1/2/4/8).
   function automatic logic [3:0] size_of(input logic [2:0] wid);
      logic [3:0] n;
      case (wid[1:0])
         2'b00:   n = 4'd1;
         2'b01:   n = 4'd2;
         2'b10:   n = 4'd4;
         default: n = 4'd8;
      endcase
      return n;
   endfunction

   // Expand a 16-entry byte-enable vector into a 128-bit bit mask.
   function automatic logic [127:0] bit_mask(input logic [15:0] bm);
      logic [127:0] m;
      m = 128'd0;
      for (int i = 0; i < 16; i++) begin
         m[8*i +: 8] = {8{bm[i]}};
      end
      return m;
   endfunction

   // Insert the low n store bytes at byte offset off of the two-word window.
   function automatic logic [127:0] store_merge(input logic [127:0] old,
                                                input logic [63:0]  wdata,
                                                input logic [2:0]   off,
                                                input logic [3:0]   n);
      logic [15:0]  bm;
      logic [127:0] bits;
      logic [127:0] data;
      bm   = ((16'd1 << n) - 16'd1) << off;
      bits = bit_mask(bm);
      data = {64'd0, wdata} << {off, 3'b000};
      return (data & bits) | (old & ~bits);
   endfunction

   // Keep the low bytes of the lane-aligned value and sign/zero extend them.
   function automatic logic [63:0] load_extend(input logic [63:0] raw,
                                               input logic [2:0]  wid);
      logic [63:0] r;
      case (wid)
         3'b000:  r = {{56{raw[7]}},  raw[7:0]};
         3'b001:  r = {{48{raw[15]}}, raw[15:0]};
         3'b010:  r = {{32{raw[31]}}, raw[31:0]};
         3'b100:  r = {56'd0, raw[7:0]};
         3'b101:  r = {48'd0, raw[15:0]};
         3'b110:  r = {32'd0, raw[31:0]};
         default: r = raw;
      endcase
      return r;
   endfunction

   logic [2:0]            state_q, state_d;
   logic                  we_q, we_d;
   logic [2:0]            wid_q, wid_d;
   logic [2:0]            off_q, off_d;
   logic [RAM_SIZE-1:0]   word_q, word_d;
   logic [63:0]           wdata_q, wdata_d;
   logic                  cross_q, cross_d;
   logic                  err_q, err_d;
   logic [63:0]           w0_q, w0_d;
   logic [63:0]           w1_q, w1_d;
   logic                  ready_q, ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [63:0]           rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [RAM_SIZE-1:0]   ram_addr_q, ram_addr_d;
   logic                  ram_ewr_q, ram_ewr_d;
   logic [63:0]           ram_data_q, ram_data_d;

   logic                  accept_s;
   logic [3:0]            req_size_s;
   logic [RAM_SIZE-1:0]   req_word_s;
   logic                  req_cross_s;
   logic                  req_err_s;
   logic [127:0]          merged_s;
   logic [127:0]          window_s;
   logic [63:0]           loaded_s;

   assign accept_s    = req_valid_i & ready_q;
   assign req_size_s  = size_of(req_wid_i);
   assign req_word_s  = req_addr_i[RAM_SIZE+2:3];
   assign req_cross_s = (({1'b0, req_addr_i[2:0]} + req_size_s) > 4'd8);
   // A crossing access in the last word would need word 0 next: rejected.
   assign req_err_s   = (req_wid_i == 3'b111)
                      | (req_we_i & req_wid_i[2])
                      | (|req_addr_i[63:RAM_SIZE+3])
                      | (req_cross_s & (req_word_s == WORD_LAST));

   // Sequencing: request capture, RAM word capture and state transitions.
   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      wid_d   = wid_q;
      off_d   = off_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      cross_d = cross_q;
      err_d   = err_q;
      w0_d    = w0_q;
      w1_d    = w1_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               we_d    = req_we_i;
               wid_d   = req_wid_i;
               off_d   = req_addr_i[2:0];
               word_d  = req_word_s;
               wdata_d = req_wdata_i;
               cross_d = req_cross_s;
               err_d   = req_err_s;
               w0_d    = 64'd0;
               w1_d    = 64'd0;
               if (req_err_s) begin
                  state_d = S_RESP;
               end else if (req_we_i && (req_addr_i[2:0] == 3'd0) && (req_size_s == 4'd8)) begin
                  state_d = S_WR0;
               end else begin
                  state_d = S_RD0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD0: begin
            w0_d = ram_data_i;
            if (cross_q) begin
               state_d = S_RD1;
            end else if (we_q) begin
               state_d = S_WR0;
            end else begin
               state_d = S_RESP;
            end
         end
         S_RD1: begin
            w1_d = ram_data_i;
            if (we_q) begin
               state_d = S_WR0;
            end else begin
               state_d = S_RESP;
            end
         end
         S_WR0: begin
            if (cross_q) begin
               state_d = S_WR1;
            end else begin
               state_d = S_RESP;
            end
         end
         S_WR1:   state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs computed from the upcoming state and captured data.
   always_comb begin
      window_s    = {w1_d, w0_d};
      merged_s    = store_merge(window_s, wdata_d, off_d, size_of(wid_d));
      loaded_s    = load_extend(64'(window_s >> {off_d, 3'b000}), wid_d);
      ready_d     = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_RESP);
      rsp_err_d   = (state_d == S_RESP) & err_d;
      if ((state_d == S_RESP) && !we_d && !err_d) begin
         rsp_rdata_d = loaded_s;
      end else begin
         rsp_rdata_d = 64'd0;
      end
      ram_ewr_d  = ~((state_d == S_WR0) | (state_d == S_WR1));
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      case (state_d)
         S_RD0: ram_addr_d = word_d;
         S_RD1: ram_addr_d = word_d + WORD_ONE;
         S_WR0: begin
            ram_addr_d = word_d;
            ram_data_d = merged_s[63:0];
         end
         S_WR1: begin
            ram_addr_d = word_d + WORD_ONE;
            ram_data_d = merged_s[127:64];
         end
         default: begin
            ram_addr_d = ram_addr_q;
            ram_data_d = ram_data_q;
         end
      endcase
   end

   // State and output registers; reset abandons any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         we_q        <= 1'b0;
         wid_q       <= 3'd0;
         off_q       <= 3'd0;
         word_q      <= {RAM_SIZE{1'b0}};
         wdata_q     <= 64'd0;
         cross_q     <= 1'b0;
         err_q       <= 1'b0;
         w0_q        <= 64'd0;
         w1_q        <= 64'd0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 64'd0;
         rsp_err_q   <= 1'b0;
         ram_addr_q  <= {RAM_SIZE{1'b0}};
         ram_ewr_q   <= 1'b1;
         ram_data_q  <= 64'd0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         wid_q       <= wid_d;
         off_q       <= off_d;
         word_q      <= word_d;
         wdata_q     <= wdata_d;
         cross_q     <= cross_d;
         err_q       <= err_d;
         w0_q        <= w0_d;
         w1_q        <= w1_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         ram_addr_q  <= ram_addr_d;
         ram_ewr_q   <= ram_ewr_d;
         ram_data_q  <= ram_data_d;
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign ram_addr_o  = ram_addr_q;
   assign ram_ewr_o   = ram_ewr_q;
   assign ram_wid_o   = 3'b011;
   assign ram_data_o  = ram_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural 64-bit RAM model.
module tb_lsu_ctrl;

   logic        clk;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [63:0] req_addr_i;
   logic [2:0]  req_wid_i;
   logic [63:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [63:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic [15:0] ram_addr_o;
   logic        ram_ewr_o;
   logic [2:0]  ram_wid_o;
   logic [63:0] ram_data_o;
   logic [63:0] ram_data_i;

   logic [63:0] mem [0:65535];
   int          wr_cnt;
   int          rsp_cnt;
   int          n_vec;
   int          n_err;

   lsu_ctrl #(.DATA_WIDTH(64), .RAM_SIZE(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_wid_i   (req_wid_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .ram_addr_o  (ram_addr_o),
      .ram_ewr_o   (ram_ewr_o),
      .ram_wid_o   (ram_wid_o),
      .ram_data_o  (ram_data_o),
      .ram_data_i  (ram_data_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign ram_data_i = mem[ram_addr_o];

   // RAM write port plus write-cycle and response-pulse counters.
   always @(posedge clk) begin
      if (ram_ewr_o == 1'b0) begin
         mem[ram_addr_o] <= ram_data_o;
         wr_cnt          <= wr_cnt + 1;
      end
      if (rsp_valid_o == 1'b1) begin
         rsp_cnt <= rsp_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One request from ready to response, checking latency, result and writes.
   task automatic run(input string tag, input logic we, input logic [63:0] addr,
                      input logic [2:0] wid, input logic [63:0] wd, input int exp_lat,
                      input logic [63:0] exp_rd, input logic exp_err, input int exp_wr);
      int   guard;
      int   lat;
      int   w0c;
      logic rdy_seen;
      guard = 0;
      while (req_ready_o !== 1'b1 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      chk({tag, "/ready"}, 64'(req_ready_o), 64'd1);
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_addr_i  = addr;
      req_wid_i   = wid;
      req_wdata_i = wd;
      w0c         = wr_cnt;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      lat      = 1;
      rdy_seen = 1'b0;
      while (rsp_valid_o !== 1'b1 && lat < 20) begin
         if (req_ready_o) rdy_seen = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      if (req_ready_o) rdy_seen = 1'b1;
      chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "/rdata"}, rsp_rdata_o, exp_rd);
      chk({tag, "/err"}, 64'(rsp_err_o), 64'(exp_err));
      chk({tag, "/ready_low"}, 64'(rdy_seen), 64'd0);
      @(posedge clk); #1;
      chk({tag, "/writes"}, 64'(wr_cnt - w0c), 64'(exp_wr));
      chk({tag, "/valid_drop"}, 64'(rsp_valid_o), 64'd0);
      chk({tag, "/rdata_clr"}, {rsp_rdata_o[62:0], rsp_err_o}, 64'd0);
      chk({tag, "/ready_after"}, 64'(req_ready_o), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int w0c;
      int r0c;
      n_vec = 0;
      n_err = 0;
      wr_cnt = 0;
      rsp_cnt = 0;
      rst = 1'b1;
      req_valid_i = 1'b0;
      req_we_i    = 1'b0;
      req_addr_i  = 64'd0;
      req_wid_i   = 3'd0;
      req_wdata_i = 64'd0;

      // Reset state
      @(posedge clk); @(posedge clk); #1;
      chk("rst/ready", 64'(req_ready_o), 64'd0);
      chk("rst/ewr", 64'(ram_ewr_o), 64'd1);
      chk("rst/valid", 64'(rsp_valid_o), 64'd0);
      chk("rst/rdata", rsp_rdata_o, 64'd0);
      chk("rst/err", 64'(rsp_err_o), 64'd0);
      chk("rst/addr", 64'(ram_addr_o), 64'd0);
      chk("rst/data", ram_data_o, 64'd0);
      chk("rst/wid", 64'(ram_wid_o), 64'd3);
      @(negedge clk);
      rst = 1'b0;

      // Preload words 0x10..0x12 with full aligned stores
      run("sd_pre10", 1'b1, 64'h80, 3'b011, 64'h8877665544332211, 2, 64'd0, 1'b0, 1);
      run("sd_pre11", 1'b1, 64'h88, 3'b011, 64'h00000000DDCCBBAA, 2, 64'd0, 1'b0, 1);
      run("sd_pre12", 1'b1, 64'h90, 3'b011, 64'h0, 2, 64'd0, 1'b0, 1);
      chk("pre/mem10", mem[16], 64'h8877665544332211);

      // Loads within one word
      run("lb",  1'b0, 64'h87, 3'b000, 64'd0, 2, 64'hFFFFFFFFFFFFFF88, 1'b0, 0);
      run("lbu", 1'b0, 64'h87, 3'b100, 64'd0, 2, 64'h0000000000000088, 1'b0, 0);
      run("lh",  1'b0, 64'h82, 3'b001, 64'd0, 2, 64'h0000000000004433, 1'b0, 0);

      // Loads crossing into word 0x11
      run("lw_x",  1'b0, 64'h86, 3'b010, 64'd0, 3, 64'hFFFFFFFFBBAA8877, 1'b0, 0);
      run("lwu_x", 1'b0, 64'h86, 3'b110, 64'd0, 3, 64'h00000000BBAA8877, 1'b0, 0);

      // Half-word read-modify-write, upper store bits must be dropped
      run("sh", 1'b1, 64'h85, 3'b001, 64'hFFFFFFFFFFFFBEEF, 3, 64'd0, 1'b0, 1);
      chk("sh/mem10", mem[16], 64'h88BEEF5544332211);

      // Doubleword store crossing from word 0x11 into 0x12
      run("sd_x", 1'b1, 64'h8C, 3'b011, 64'h0123456789ABCDEF, 5, 64'd0, 1'b0, 2);
      chk("sd_x/mem11", mem[17], 64'h89ABCDEFDDCCBBAA);
      chk("sd_x/mem12", mem[18], 64'h0000000001234567);
      run("ld", 1'b0, 64'h88, 3'b011, 64'd0, 2, 64'h89ABCDEFDDCCBBAA, 1'b0, 0);

      // Rejected requests
      run("err_range", 1'b0, 64'h80000, 3'b011, 64'd0, 1, 64'd0, 1'b1, 0);
      run("err_sbu",   1'b1, 64'h80,    3'b100, 64'h55, 1, 64'd0, 1'b1, 0);
      run("err_w111",  1'b0, 64'h80,    3'b111, 64'd0, 1, 64'd0, 1'b1, 0);
      run("err_wrap",  1'b1, 64'h7FFFC, 3'b011, 64'h1, 1, 64'd0, 1'b1, 0);
      chk("err/mem10", mem[16], 64'h88BEEF5544332211);

      // Reset during RD1 of a crossing store
      while (req_ready_o !== 1'b1) begin
         @(posedge clk); #1;
      end
      req_valid_i = 1'b1;
      req_we_i    = 1'b1;
      req_addr_i  = 64'h8C;
      req_wid_i   = 3'b011;
      req_wdata_i = 64'hFFFFFFFFFFFFFFFF;
      w0c = wr_cnt;
      r0c = rsp_cnt;
      @(posedge clk); #1;
      req_valid_i = 1'b0;
      chk("mid/rd0_addr", 64'(ram_addr_o), 64'h11);
      @(posedge clk); #1;
      chk("mid/rd1_addr", 64'(ram_addr_o), 64'h12);
      rst = 1'b1;
      #1;
      chk("mid/ready_rst", 64'(req_ready_o), 64'd0);
      chk("mid/ewr_rst", 64'(ram_ewr_o), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("mid/ready_held", 64'(req_ready_o), 64'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mid/ready_back", 64'(req_ready_o), 64'd1);
      repeat (6) @(posedge clk);
      #1;
      chk("mid/no_rsp", 64'(rsp_cnt - r0c), 64'd0);
      chk("mid/no_write", 64'(wr_cnt - w0c), 64'd0);
      chk("mid/mem11", mem[17], 64'h89ABCDEFDDCCBBAA);
      chk("mid/mem12", mem[18], 64'h0000000001234567);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
